sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
Parametrised successor to the team's fixed synchronous FIFO.
- Single clock domain; data width and depth are configurable.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer blocks in the same clock domain and is the drop-in replacement for the existing FIFO: its base port names are a superset of the existing FIFO's.

Parameters:
- DATA_W, 8: data width in bits, >=1.
- DEPTH, 16: number of entries; power of two, >=2.
- AF_THRESH, DEPTH-2: almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- FWFT, 0: 0 = registered read, data 1 cycle after an accepted rd; 1 = head word visible on data_out whenever !empty.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr  in  1  write request.
- rd  in  1  read request.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  read data.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  1-cycle pulse: write rejected.
- underflow  out  1  1-cycle pulse: read rejected.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - wr_ptr = rd_ptr = 0, count = 0.
  - data_out = 0, overflow = underflow = 0.
  - Hence empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Memory contents are not reset.
- Accept rules:
  - rd_acc = rd && !empty.
  - wr_acc = wr && (!full || rd_acc). A write into a full FIFO succeeds only when a read is accepted in the same cycle.
- Pointers:
  - Each pointer is $clog2(DEPTH) bits and advances by 1 per accepted operation.
  - Pointers wrap naturally from DEPTH-1 to 0.
- Count update:
  - +1 on wr_acc && !rd_acc.
  - -1 on rd_acc && !wr_acc.
  - Unchanged when both are accepted or neither.
- Status flags:
  - empty, full, almost_full and almost_empty are decoded combinationally from the registered count, so they are glitch-free.
  - All flags reflect the new count in the cycle after the accepting edge.
- Error pulses:
  - overflow is registered: 1 in the cycle after an edge where wr && !wr_acc.
  - underflow is registered: 1 in the cycle after an edge where rd && !rd_acc.
  - A rejected operation changes no pointer, count or memory state.
- FWFT = 0:
  - On rd_acc, data_out <= mem[rd_ptr] at that edge.
  - data_out holds its value otherwise, including on a rejected read.
- FWFT = 1:
  - data_out = mem[rd_ptr], asynchronous read.
  - data_out is 0 when empty.
  - rd_acc pops the head; the next word is visible in the same cycle as the pointer update.
- Simultaneous rd && wr when empty:
  - The read is rejected (underflow pulse); the write is accepted; count becomes 1.
  - In FWFT mode the written word appears on data_out in the next cycle; there is no same-cycle bypass.
- Simultaneous rd && wr when full: both are accepted; count stays DEPTH; no overflow.
- Reset mid-operation: all state returns immediately to reset values; in-flight requests are discarded.
- Bounded by the same-cycle accept rules above, every operation takes effect within a single clock.

Decomposition:
- Package sync_fifo_pkg:
  - Default DATA_W and DEPTH constants.
  - A ptr_w(depth) helper function returning $clog2(depth).
  - A status struct typedef {empty, full, almost_empty, almost_full} for bench and monitor use.
- Sub-module fifo_mem: a simple dual-port RAM with one write port, parametrised by DATA_W and DEPTH.
  - FWFT = 0: synchronous read port.
  - FWFT = 1: asynchronous read port.
- Top level holds pointers, count, flag decode and error pulses.

Test Plan:
1. DEPTH=8, FWFT=0: write 0x01..0x08 with no reads -> full=1 and count=8 after the 8th edge; a 9th write -> overflow pulse for 1 cycle and count stays 8.
2. Drain the full FIFO with 8 reads -> data_out = 0x01..0x08 in order, each 1 cycle after its rd; empty=1 after the last; a 9th read -> underflow pulse and data_out holds 0x08.
3. AF_THRESH=6, AE_THRESH=2: fill one word at a time -> almost_empty drops when count reaches 3; almost_full rises when count reaches 6.
4. Full FIFO with rd=wr=1 for 4 cycles -> count stays 8, no overflow, and output order is preserved across pointer wrap.
5. FWFT=1: write 0xA5 into the empty FIFO -> data_out = 0xA5 in the next cycle with no rd; rd && wr on the empty FIFO -> underflow pulse and count = 1.
6. Assert rst_n=0 mid-burst with count=5 -> count=0, empty=1 and data_out=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for the parametrised synchronous FIFO:
//   DEF_DATA_W / DEF_DEPTH : default geometry used by the interface and top
//   ptr_w(depth)           : read/write pointer width for a given depth
//   fifo_status_t          : bundled status flags for benches and monitors
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    // Pointer width; DEPTH is a power of two, so pointers wrap for free.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } fifo_status_t;

endpackage

// File: rtl/sync_fifo_param_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_if
// Handshake/data bundle between a producer/consumer and sync_fifo_param.
//   wr, rd, data_in                 : requests and write data (master drives)
//   data_out                        : read data
//   empty, full, almost_full,
//   almost_empty, count             : occupancy status
//   overflow, underflow             : one-cycle rejected-operation pulses
// Modports: master = user side, slave = FIFO side.
// -----------------------------------------------------------------------------
interface sync_fifo_param_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);

    logic                    wr;
    logic                    rd;
    logic [DATA_W-1:0]       data_in;
    logic [DATA_W-1:0]       data_out;
    logic                    empty;
    logic                    full;
    logic                    almost_full;
    logic                    almost_empty;
    logic [ptr_w(DEPTH):0]   count;
    logic                    overflow;
    logic                    underflow;

    modport master (
        output wr, rd, data_in,
        input  data_out, empty, full, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr, rd, data_in,
        output data_out, empty, full, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_param_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Simple dual-port RAM: one write port, one read port.
//   clk, rst_n : clock; reset clears only the registered read data
//   we, waddr, wdata : write port, written on the rising edge
//   re, raddr, rdata : read port
// FWFT = 0 -> synchronous read: rdata updates at the edge where re is high
//             and holds otherwise.
// FWFT = 1 -> asynchronous read: rdata follows mem[raddr] combinationally.
// The storage array itself is never reset.
// -----------------------------------------------------------------------------
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter bit FWFT   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [ptr_w(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    re,
    input  logic [ptr_w(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]       rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (FWFT) begin : g_async_rd
            // Read-before-write at the edge is implicit: the head word is
            // sampled from the array before any same-edge write lands.
            assign rdata = mem[raddr];

            logic unused_sync_rd;
            assign unused_sync_rd = &{1'b0, re, rst_n};
        end else begin : g_sync_rd
            logic [DATA_W-1:0] rdata_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (re) begin
                    rdata_q <= mem[raddr];
                end
            end

            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO with configurable width/depth, programmable almost-full /
// almost-empty thresholds, occupancy count, overflow/underflow pulses and an
// optional first-word-fall-through read mode.
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sync_fifo_param_if.slave (wr, rd, data_in, data_out, empty, full,
//           almost_full, almost_empty, count, overflow, underflow)
// Parameters DATA_W / DEPTH must match those of the connected interface.
// -----------------------------------------------------------------------------
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter bit FWFT      = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    sync_fifo_param_if.slave    bus
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              rd_acc;
    logic              wr_acc;
    logic [DATA_W-1:0] mem_rdata;
    fifo_status_t      st;

    // Flags come straight from the registered count so they never glitch.
    always_comb begin
        st              = '0;
        st.empty        = (count_q == '0);
        st.full         = (count_q == CNT_W'(DEPTH));
        st.almost_full  = (count_q >= CNT_W'(AF_THRESH));
        st.almost_empty = (count_q <= CNT_W'(AE_THRESH));
    end

    // A write into a full FIFO is legal only when a read frees a slot in the
    // same cycle; a read on empty is always rejected (no same-cycle bypass).
    assign rd_acc = bus.rd && !st.empty;
    assign wr_acc = bus.wr && (!st.full || rd_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            overflow_q  <= bus.wr && !wr_acc;
            underflow_q <= bus.rd && !rd_acc;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .FWFT   (FWFT)
    ) u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wr_acc),
        .waddr  (wr_ptr),
        .wdata  (bus.data_in),
        .re     (rd_acc),
        .raddr  (rd_ptr),
        .rdata  (mem_rdata)
    );

    generate
        if (FWFT) begin : g_fwft_out
            // Stale array contents must not leak out while empty.
            assign bus.data_out = st.empty ? '0 : mem_rdata;
        end else begin : g_reg_out
            assign bus.data_out = mem_rdata;
        end
    endgenerate

    assign bus.empty        = st.empty;
    assign bus.full         = st.full;
    assign bus.almost_full  = st.almost_full;
    assign bus.almost_empty = st.almost_empty;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
